seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_mul_seq.sv | 71 +++++++
 rtl/seq_alu.sv | 171 +++++++++++++++++
 tb/tb_seq_alu.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Opcode constants and controller state encoding shared by the
//               sequential ALU and its multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

   localparam logic [2:0] OP_NOT = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_XOR = 3'b010;
   localparam logic [2:0] OP_AND = 3'b011;
   localparam logic [2:0] OP_MUL = 3'b100;
   localparam logic [2:0] OP_ADD = 3'b101;
   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_NOP = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_MUL  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_mul_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_mul_seq
// Description : Unsigned H x H shift-add multiplier, one partial product per
//               clock, exactly H steps after start. 'done' is high during the
//               cycle whose closing edge performs the final step, and
//               'product' then shows the value after that step, so the caller
//               can register the finished product on that same edge.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mul_seq
   import alu_pkg::*;
#(
   parameter int H = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [H-1:0]   a,
   input  logic [H-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic [2*H-1:0] product
);

   localparam int CW = $clog2(H + 1);

   logic [2*H-1:0] mcand;
   logic [2*H-1:0] acc;
   logic [2*H-1:0] step_acc;
   logic [H-1:0]   mplier;
   logic [CW-1:0]  count;

   // Accumulator value after the current step: add the shifted multiplicand when the current multiplier bit is set
   always_comb begin
      step_acc = acc;
      if (mplier[0]) begin
         step_acc = acc + mcand;
      end
   end

   // Operand capture on start, then one shift-add step per cycle while busy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         count  <= '0;
         busy   <= 1'b0;
      end else if (start) begin
         mcand  <= {{H{1'b0}}, a};
         mplier <= b;
         acc    <= '0;
         count  <= CW'(H);
         busy   <= 1'b1;
      end else if (busy) begin
         acc    <= step_acc;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         count  <= count - CW'(1);
         if (count == CW'(1)) begin
            busy <= 1'b0;
         end
      end
   end

   assign done    = busy && (count == CW'(1));
   assign product = step_acc;

endmodule
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
// Module      : seq_alu
// Description : Handshaked ALU. Logic and add/sub operations complete in one
//               cycle; MUL runs an H-step shift-add multiply on the low
//               halves of the operands. Result and flags are held in
//               registers until the consumer accepts them.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       opcode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             flag_z,
   output logic             flag_c,
   output logic             flag_v
);

   localparam int H = WIDTH / 2;

   generate
      if ((WIDTH < 4) || ((WIDTH % 2) != 0)) begin : g_width_check
         $error("seq_alu: WIDTH must be even and >= 4");
      end
   endgenerate

   logic             rst_meta;
   logic             rst_sync_n;
   logic             armed;
   state_t           state;
   state_t           state_next;
   logic             in_accept;
   logic             mul_start;
   logic             mul_busy;
   logic             mul_done;
   logic [WIDTH-1:0] mul_product;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] alu_res;
   logic             alu_c;
   logic             alu_v;

   // Reset asserts asynchronously and releases two clock edges after rst_n rises
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_meta   <= 1'b0;
         rst_sync_n <= 1'b0;
      end else begin
         rst_meta   <= 1'b1;
         rst_sync_n <= rst_meta;
      end
   end

   // Holds off input acceptance until the synchronised reset has fully released
   always_ff @(posedge clk or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         armed <= 1'b0;
      end else begin
         armed <= 1'b1;
      end
   end

   assign in_ready  = (state == ST_IDLE) && armed && !mul_busy;
   assign out_valid = (state == ST_DONE);
   assign in_accept = in_valid && in_ready;
   assign mul_start = in_accept && (opcode == OP_MUL);

   alu_mul_seq #(
      .H (H)
   ) u_mul (
      .clk     (clk),
      .rst_n   (rst_sync_n),
      .start   (mul_start),
      .a       (a[H-1:0]),
      .b       (b[H-1:0]),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_product)
   );

   // Controller state register
   always_ff @(posedge clk or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state: accept in IDLE, wait out the multiplier, hold in DONE until taken
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (in_accept) begin
               state_next = (opcode == OP_MUL) ? ST_MUL : ST_DONE;
            end
         end
         ST_MUL: begin
            if (mul_done) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Single-cycle operations; the borrow of a-b is the top bit of the widened difference
   always_comb begin
      sum     = {1'b0, a} + {1'b0, b};
      diff    = {1'b0, a} - {1'b0, b};
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (opcode)
         OP_NOT: alu_res = ~a;
         OP_OR:  alu_res = a | b;
         OP_XOR: alu_res = a ^ b;
         OP_AND: alu_res = a & b;
         OP_ADD: begin
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH];
            alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res = diff[WIDTH-1:0];
            alu_c   = diff[WIDTH];
            alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         default: alu_res = '0;
      endcase
   end

   // Output registers: loaded on acceptance (single-cycle ops) or on the final multiply step, held otherwise
   always_ff @(posedge clk or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         result <= '0;
         flag_z <= 1'b0;
         flag_c <= 1'b0;
         flag_v <= 1'b0;
      end else if (in_accept && (opcode != OP_MUL)) begin
         result <= alu_res;
         flag_z <= (alu_res == '0);
         flag_c <= alu_c;
         flag_v <= alu_v;
      end else if ((state == ST_MUL) && mul_done) begin
         result <= mul_product;
         flag_z <= (mul_product == '0);
         flag_c <= 1'b0;
         flag_v <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_alu
// Description : Self-checking bench for seq_alu (WIDTH = 8): directed vectors
//               with literal expectations plus a scoreboard fed by an
//               arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_alu;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] a = 8'h00;
   logic [7:0] b = 8'h00;
   logic [2:0] opcode = 3'b111;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] result;
   logic       flag_z;
   logic       flag_c;
   logic       flag_v;

   int checks = 0;
   int errors = 0;

   logic [10:0] exp_q[$];
   logic [11:0] held = '0;
   bit          hold_prev = 1'b0;

   seq_alu #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .opcode    (opcode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flag_z    (flag_z),
      .flag_c    (flag_c),
      .flag_v    (flag_v)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: {z, c, v, result[7:0]} from plain integer arithmetic
   function automatic logic [10:0] model(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
      int ux, uy, sx, sy, r;
      logic c, v;
      logic [7:0] rb;
      ux = int'(x);
      uy = int'(y);
      sx = (ux > 127) ? ux - 256 : ux;
      sy = (uy > 127) ? uy - 256 : uy;
      c  = 1'b0;
      v  = 1'b0;
      r  = 0;
      case (op)
         3'd0: r = 255 - ux;
         3'd1: r = int'(x | y);
         3'd2: r = int'(x ^ y);
         3'd3: r = int'(x & y);
         3'd4: r = (ux % 16) * (uy % 16);
         3'd5: begin
            r = ux + uy;
            c = (r > 255);
            v = (sx + sy > 127) || (sx + sy < -128);
            r = r % 256;
         end
         3'd6: begin
            c = (ux < uy);
            v = (sx - sy > 127) || (sx - sy < -128);
            r = (ux - uy + 256) % 256;
         end
         default: r = 0;
      endcase
      rb = r[7:0];
      return {(rb == 8'h00), c, v, rb};
   endfunction

   // Scoreboard: model every accepted operation, compare on every output transfer, check hold stability
   always @(negedge clk) begin
      logic [10:0] e;
      if (!rst_n) begin
         exp_q.delete();
         hold_prev = 1'b0;
      end else begin
         if (hold_prev) begin
            check({out_valid, flag_z, flag_c, flag_v, result} == held, "hold_stable_sb",
                  {20'h0, out_valid, flag_z, flag_c, flag_v, result}, {20'h0, held});
         end
         if (out_valid) begin
            check(exp_q.size() != 0, "no_spurious_out", 32'(exp_q.size()), 32'd1);
            if (out_ready && exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check(result == e[7:0], "sb_result", {24'h0, result}, {24'h0, e[7:0]});
               check({flag_z, flag_c, flag_v} == e[10:8], "sb_flags_zcv",
                     {29'h0, flag_z, flag_c, flag_v}, {29'h0, e[10:8]});
            end
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(model(opcode, a, b));
         end
         hold_prev = out_valid && !out_ready;
         held      = {out_valid, flag_z, flag_c, flag_v, result};
      end
   end

   // Directed operation: garbage on the inputs after acceptance, optional hold with out_ready low
   task automatic run_op(input logic [2:0] op, input logic [7:0] aa, input logic [7:0] bb, input int hold,
                         input logic [7:0] er, input logic ez, input logic ec, input logic ev, input int elat);
      int g;
      int lat;
      a        = aa;
      b        = bb;
      opcode   = op;
      in_valid = 1'b1;
      g = 0;
      while (!in_ready && g < 20) begin
         @(posedge clk); #1;
         g++;
      end
      check(in_ready == 1'b1, "in_ready_wait", {31'h0, in_ready}, 32'd1);
      @(posedge clk); #1;
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
         if (out_valid) begin
            lat = k;
            break;
         end
         a      = 8'($urandom);
         b      = 8'($urandom);
         opcode = 3'($urandom);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      check(lat == elat, "latency", 32'(lat), 32'(elat));
      check(result == er, "result", {24'h0, result}, {24'h0, er});
      check({flag_z, flag_c, flag_v} == {ez, ec, ev}, "flags_zcv",
            {29'h0, flag_z, flag_c, flag_v}, {29'h0, ez, ec, ev});
      for (int k = 0; k < hold; k++) begin
         @(posedge clk); #1;
         check(!in_ready && out_valid && result == er && flag_z == ez, "hold_directed",
               {22'h0, in_ready, out_valid, flag_z, result}, {23'h0, 1'b1, ez, er});
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check(out_valid == 1'b0, "out_released", {31'h0, out_valid}, 32'd0);
   endtask

   // Randomised operation with random back-pressure; the scoreboard does the checking
   task automatic rand_op(input logic [2:0] op, input logic [7:0] aa, input logic [7:0] bb);
      int  g;
      bit  acc;
      bit  fin;
      a        = aa;
      b        = bb;
      opcode   = op;
      in_valid = 1'b1;
      g   = 0;
      acc = 1'b0;
      fin = 1'b0;
      while (!fin && g < 100) begin
         out_ready = 1'($urandom_range(0, 1));
         if (!acc && in_ready) begin
            acc = 1'b1;
         end else if (acc && out_valid && out_ready) begin
            fin = 1'b1;
         end
         @(posedge clk); #1;
         g++;
         if (acc) begin
            in_valid = 1'b0;
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      if (!fin) begin
         check(1'b0, "rand_op_timeout", 32'(g), 32'd100);
      end
   endtask

   initial begin
      // Reset state
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check(out_valid == 1'b0, "reset_out_valid", {31'h0, out_valid}, 32'd0);
      check(result == 8'h00, "reset_result", {24'h0, result}, 32'd0);
      check({flag_z, flag_c, flag_v} == 3'b000, "reset_flags", {29'h0, flag_z, flag_c, flag_v}, 32'd0);

      // A request waiting across release must not move the block on the first edge
      a        = 8'h00;
      b        = 8'h00;
      opcode   = 3'b111;
      in_valid = 1'b1;
      rst_n    = 1'b1;
      @(posedge clk); #1;
      check(out_valid == 1'b0, "no_change_edge1", {31'h0, out_valid}, 32'd0);

      run_op(3'b111, 8'h00, 8'h00, 0, 8'h00, 1'b1, 1'b0, 1'b0, 1);   // NOP
      run_op(3'b101, 8'hFF, 8'h01, 0, 8'h00, 1'b1, 1'b1, 1'b0, 1);   // ADD wrap with carry
      run_op(3'b101, 8'h7F, 8'h01, 0, 8'h80, 1'b0, 1'b0, 1'b1, 1);   // ADD signed overflow
      run_op(3'b110, 8'h80, 8'h01, 0, 8'h7F, 1'b0, 1'b0, 1'b1, 1);   // SUB signed overflow
      run_op(3'b110, 8'h01, 8'h02, 0, 8'hFF, 1'b0, 1'b1, 1'b0, 1);   // SUB borrow
      run_op(3'b000, 8'h0F, 8'h00, 0, 8'hF0, 1'b0, 1'b0, 1'b0, 1);   // NOT
      run_op(3'b001, 8'h0F, 8'hF0, 0, 8'hFF, 1'b0, 1'b0, 1'b0, 1);   // OR
      run_op(3'b100, 8'hAF, 8'h3F, 0, 8'hE1, 1'b0, 1'b0, 1'b0, 5);   // MUL 0xF*0xF
      run_op(3'b100, 8'h10, 8'hFF, 0, 8'h00, 1'b1, 1'b0, 1'b0, 5);   // MUL by zero low half
      run_op(3'b010, 8'h5A, 8'h5A, 10, 8'h00, 1'b1, 1'b0, 1'b0, 1);  // XOR held 10 cycles
      run_op(3'b011, 8'hC3, 8'h7E, 0, 8'h42, 1'b0, 1'b0, 1'b0, 1);   // AND leaves nonzero result

      // Reset in the middle of a multiply
      a        = 8'hAF;
      b        = 8'h3F;
      opcode   = 3'b100;
      in_valid = 1'b1;
      for (int g = 0; g < 20 && !in_ready; g++) begin
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check(out_valid == 1'b0 && result == 8'h00 && {flag_z, flag_c, flag_v} == 3'b000, "reset_mid_mul",
            {20'h0, out_valid, flag_z, flag_c, flag_v, result}, 32'd0);
      @(negedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         check(out_valid == 1'b0 && result == 8'h00, "no_stale_after_reset",
               {23'h0, out_valid, result}, 32'd0);
         @(posedge clk); #1;
      end
      run_op(3'b011, 8'hF0, 8'h3C, 0, 8'h30, 1'b0, 1'b0, 1'b0, 1);   // AND after reset

      // Random operations against the model with random back-pressure
      for (int n = 0; n < 40; n++) begin
         rand_op(3'($urandom), 8'($urandom), 8'($urandom));
      end
      repeat (2) @(posedge clk);
      #1;
      check(exp_q.size() == 0, "queue_drained", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
